// File: rtl/vga_scanout_reader_if.sv
// Scan-out bundle: video RAM read port, VGA pins, and CPU-visible counters/frame pulse.
// The reader is the master; the RAM/pin side is the slave.
interface vga_scanout_reader_if;
  logic       iEnable;
  logic [9:0] oReadAddress;
  logic [2:0] iReadData;
  logic       oHorizontalSync;
  logic       oVerticalSync;
  logic       oRed;
  logic       oGreen;
  logic       oBlue;
  logic [9:0] oColumnCount;
  logic [9:0] oRowCount;
  logic       oFrameStart;

  modport master (
    input  iEnable, iReadData,
    output oReadAddress, oHorizontalSync, oVerticalSync, oRed, oGreen, oBlue,
    output oColumnCount, oRowCount, oFrameStart
  );

  modport slave (
    output iEnable, iReadData,
    input  oReadAddress, oHorizontalSync, oVerticalSync, oRed, oGreen, oBlue,
    input  oColumnCount, oRowCount, oFrameStart
  );
endinterface

// File: rtl/vga_scanout_reader.sv
// VGA timing generator and video RAM reader; RGB and syncs are delayed two enabled
// clocks so they line up with the RAM's one-cycle read latency.
module vga_scanout_reader #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input logic                  Clock,
  input logic                  Reset,
  vga_scanout_reader_if.master bus
);

  localparam logic [9:0] HVisibleEnd = 10'(H_VISIBLE);
  localparam logic [9:0] HSyncStart  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HSyncEnd    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] HLast       = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] VVisibleEnd = 10'(V_VISIBLE);
  localparam logic [9:0] VSyncStart  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VSyncEnd    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] VLast       = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  logic [9:0] columnQ, columnD;
  logic [9:0] rowQ, rowD;
  logic       lineEnd, frameEnd;
  logic       visible, hsN, vsN;
  logic       visibleQ, hsN1Q, vsN1Q;
  logic       hsN2Q, vsN2Q;
  logic [2:0] rgbQ;
  logic       frameStartQ;

  always_comb begin
    lineEnd  = (columnQ == HLast);
    frameEnd = lineEnd && (rowQ == VLast);
    columnD  = lineEnd ? 10'd0 : columnQ + 10'd1;
    rowD     = rowQ;
    if (lineEnd) begin
      rowD = (rowQ == VLast) ? 10'd0 : rowQ + 10'd1;
    end
  end

  always_comb begin
    visible = (columnQ < HVisibleEnd) && (rowQ < VVisibleEnd);
    hsN     = !((columnQ >= HSyncStart) && (columnQ < HSyncEnd));
    vsN     = !((rowQ >= VSyncStart) && (rowQ < VSyncEnd));
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      columnQ     <= '0;
      rowQ        <= '0;
      visibleQ    <= 1'b0;
      hsN1Q       <= 1'b1;
      vsN1Q       <= 1'b1;
      hsN2Q       <= 1'b1;
      vsN2Q       <= 1'b1;
      rgbQ        <= 3'b000;
      frameStartQ <= 1'b0;
    end else begin
      // Pulse only on an enabled wrap; a stall clears it rather than stretching it.
      frameStartQ <= bus.iEnable && frameEnd;
      if (bus.iEnable) begin
        columnQ  <= columnD;
        rowQ     <= rowD;
        visibleQ <= visible;
        hsN1Q    <= hsN;
        vsN1Q    <= vsN;
        hsN2Q    <= hsN1Q;
        vsN2Q    <= vsN1Q;
        // iReadData here belongs to the address stage 1 was issued with.
        rgbQ     <= visibleQ ? bus.iReadData : 3'b000;
      end
    end
  end

  // Rows past the visible area alias into the 5-bit field; blanking hides them.
  assign bus.oReadAddress    = {rowQ[8:4], columnQ[9:5]};
  assign bus.oHorizontalSync = hsN2Q;
  assign bus.oVerticalSync   = vsN2Q;
  assign bus.oRed            = rgbQ[2];
  assign bus.oGreen          = rgbQ[1];
  assign bus.oBlue           = rgbQ[0];
  assign bus.oColumnCount    = columnQ;
  assign bus.oRowCount       = rowQ;
  assign bus.oFrameStart     = frameStartQ;

endmodule
